// File: rtl/sys_defs.sv
// sys_defs: shared widths, fixed-point constants and lane/vector types
package sys_defs;
  localparam int ARR_WIDTH = 4;
  localparam int FXP_N = 16;
  localparam int FXP_FRAC = 8;
  typedef logic signed [FXP_N-1:0] lane_t;
  typedef logic signed [2*FXP_N-1:0] wide_t;
  typedef lane_t [ARR_WIDTH-1:0] vec_t;
  localparam lane_t FXP_ONE = lane_t'(1 << FXP_FRAC);
  localparam wide_t FXP_HALF = wide_t'(1 << (FXP_FRAC - 1));
endpackage

// File: rtl/sigmoid_grad_lane.sv
// sigmoid_grad_lane: per-lane clamp, y*(1-y) and gradient scaling, all combinational
module sigmoid_grad_lane
  import sys_defs::*;
(
  input  lane_t i_y,
  input  lane_t i_g,
  input  lane_t i_p,
  output lane_t o_p,
  output lane_t o_q
);
  lane_t w_yc;
  wide_t w_pp;
  wide_t w_qq;
  assign w_yc = i_y[FXP_N-1] ? '0 : (i_y > FXP_ONE ? FXP_ONE : i_y);
  assign w_pp = wide_t'(w_yc) * wide_t'(FXP_ONE - w_yc) + FXP_HALF;
  assign o_p  = lane_t'(w_pp >>> FXP_FRAC);
  // p never exceeds ONE/4, so the truncated q cannot wrap
  assign w_qq = wide_t'(i_g) * wide_t'(i_p) + FXP_HALF;
  assign o_q  = lane_t'(w_qq >>> FXP_FRAC);
endmodule

// File: rtl/vec_sigmoid_bwd.sv
// vec_sigmoid_bwd: two-stage valid/ready pipe computing dx = g*y*(1-y) per lane
module vec_sigmoid_bwd
  import sys_defs::*;
(
  input  logic clock,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  vec_t y_arr,
  input  vec_t grad_arr,
  output logic out_valid,
  input  logic out_ready,
  output vec_t grad_out
);
  logic r_s1_valid;
  logic r_s2_valid;
  vec_t r_s1_p;
  vec_t r_s1_g;
  vec_t r_grad;
  vec_t w_p;
  vec_t w_q;
  logic w_adv1;
  logic w_adv2;
  logic w_in_xfer;
  assign w_adv2    = !r_s2_valid || out_ready;
  assign w_adv1    = !r_s1_valid || w_adv2;
  assign w_in_xfer = in_valid && w_adv1;
  assign in_ready  = w_adv1;
  assign out_valid = r_s2_valid;
  assign grad_out  = r_grad;
  for (genvar i = 0; i < ARR_WIDTH; i++) begin : g_lane
    sigmoid_grad_lane u_lane (
      .i_y(y_arr[i]),
      .i_g(r_s1_g[i]),
      .i_p(r_s1_p[i]),
      .o_p(w_p[i]),
      .o_q(w_q[i])
    );
  end
  // stage 1 captures p and grad on input transfer; stage 2 captures q when it can advance
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s1_p     <= '0;
      r_s1_g     <= '0;
      r_grad     <= '0;
    end else begin
      if (w_adv1) r_s1_valid <= in_valid;
      if (w_in_xfer) begin
        r_s1_p <= w_p;
        r_s1_g <= grad_arr;
      end
      if (w_adv2) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) r_grad <= w_q;
      end
    end
  end
endmodule

// File: tb/tb_vec_sigmoid_bwd.sv
// tb_vec_sigmoid_bwd: directed self-checking bench for vec_sigmoid_bwd
module tb_vec_sigmoid_bwd;
  import sys_defs::*;
  logic clock = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  vec_t y_arr = '0;
  vec_t grad_arr = '0;
  logic in_ready;
  logic out_valid;
  vec_t grad_out;
  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  vec_sigmoid_bwd dut (
    .clock(clock),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .y_arr(y_arr),
    .grad_arr(grad_arr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .grad_out(grad_out)
  );

  function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3);
    vec_t v;
    v[0] = lane_t'(a0);
    v[1] = lane_t'(a1);
    v[2] = lane_t'(a2);
    v[3] = lane_t'(a3);
    return v;
  endfunction

  function automatic int gen_y(input int k, input int l);
    return ((k * 4 + l) * 23) % 300 - 20;
  endfunction

  function automatic int gen_g(input int k, input int l);
    return ((k * 4 + l) * 37) % 513 - 256;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_vec(input vec_t y, input vec_t g, output vec_t got,
                           output logic v_early, output logic v_late, output logic rdy);
    out_ready = 1'b1;
    y_arr = y;
    grad_arr = g;
    in_valid = 1'b1;
    #1;
    rdy = in_ready;
    tick();
    in_valid = 1'b0;
    v_early = out_valid;
    tick();
    v_late = out_valid;
    got = grad_out;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++;
    if (grad_out !== '0) begin bad++; $display("FAIL reset_grad_out: got %h want 0", grad_out); end
    tick();
    #2 rst = 1'b0;
    tick();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_vector(input string nm, input vec_t y, input vec_t g, input vec_t exp);
    vec_t got;
    logic ve, vl, rdy;
    apply_vec(y, g, got, ve, vl, rdy);
    total++;
    if (rdy !== 1'b1) begin bad++; $display("FAIL %s_in_ready: got %b want 1", nm, rdy); end
    total++;
    if (ve !== 1'b0) begin bad++; $display("FAIL %s_early_valid: got %b want 0", nm, ve); end
    total++;
    if (vl !== 1'b1) begin bad++; $display("FAIL %s_valid: got %b want 1", nm, vl); end
    total++;
    if (got !== exp) begin bad++; $display("FAIL %s_data: got %h want %h", nm, got, exp); end
  endtask

  task automatic test_basic();
    test_vector("basic", mk(128, 192, 1, 0), mk(256, -512, 256, 1280), mk(64, -96, 1, 0));
  endtask

  task automatic test_clamp();
    test_vector("clamp", mk(384, -64, 256, 64), mk(768, 768, 768, 1024), mk(0, 0, 0, 192));
  endtask

  task automatic test_extremes();
    test_vector("extreme", mk(128, 128, 128, 128), mk(32767, -32768, 32767, -32768),
                mk(8192, -8192, 8192, -8192));
  endtask

  task automatic test_backpressure();
    vec_t ys[4];
    vec_t gs[4];
    vec_t exp[4];
    int acc = 0;
    int nout = 0;
    logic rdy, ov;
    vec_t og;
    for (int k = 0; k < 4; k++) begin
      ys[k] = mk(128, 128, 128, 128);
      gs[k] = mk(256 * (k + 1), -256 * (k + 1), 64 * k, 16);
      exp[k] = mk(64 * (k + 1), -64 * (k + 1), 16 * k, 4);
    end
    for (int cyc = 0; cyc < 16; cyc++) begin
      out_ready = (cyc >= 6);
      in_valid = (acc < 4);
      if (acc < 4) begin
        y_arr = ys[acc];
        grad_arr = gs[acc];
      end
      #1;
      rdy = in_ready;
      ov = out_valid;
      og = grad_out;
      if (cyc == 5) begin
        total++;
        if (acc != 2) begin bad++; $display("FAIL bp_accepts: got %0d want 2", acc); end
        total++;
        if (rdy !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", rdy); end
      end
      if (cyc >= 2 && cyc < 6) begin
        total++;
        if (ov !== 1'b1 || og !== exp[0]) begin
          bad++;
          $display("FAIL bp_stall_hold: got v=%b %h want v=1 %h", ov, og, exp[0]);
        end
      end
      if (ov && out_ready) begin
        total++;
        if (nout >= 4 || og !== exp[nout & 3]) begin
          bad++;
          $display("FAIL bp_order: out %0d got %h want %h", nout, og, exp[nout & 3]);
        end
        nout++;
      end
      if (rdy && in_valid) acc++;
      tick();
    end
    in_valid = 1'b0;
    total++;
    if (nout != 4) begin bad++; $display("FAIL bp_count: got %0d want 4", nout); end
  endtask

  task automatic test_stream();
    int acc = 0;
    int nout = 0;
    int first = -1;
    int last = -1;
    logic rdy, ov;
    vec_t og;
    real yr, e, d;
    int drops = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 22; cyc++) begin
      in_valid = (acc < 16);
      for (int l = 0; l < ARR_WIDTH; l++) begin
        y_arr[l] = lane_t'(gen_y(acc, l));
        grad_arr[l] = lane_t'(gen_g(acc, l));
      end
      #1;
      rdy = in_ready;
      ov = out_valid;
      og = grad_out;
      if (in_valid && !rdy) drops++;
      if (ov) begin
        if (first < 0) first = cyc;
        last = cyc;
        for (int l = 0; l < ARR_WIDTH; l++) begin
          yr = gen_y(nout, l) / 256.0;
          yr = yr < 0.0 ? 0.0 : (yr > 1.0 ? 1.0 : yr);
          e = real'(gen_g(nout, l)) * yr * (1.0 - yr);
          d = real'(int'(og[l])) - e;
          total++;
          if (d > 1.0001 || d < -1.0001) begin
            bad++;
            $display("FAIL stream_data: vec %0d lane %0d got %0d want %f", nout, l, og[l], e);
          end
        end
        nout++;
      end
      if (rdy && in_valid) acc++;
      tick();
    end
    in_valid = 1'b0;
    total++;
    if (drops != 0) begin bad++; $display("FAIL stream_in_ready: got %0d stalls want 0", drops); end
    total++;
    if (nout != 16 || last - first != 15) begin
      bad++;
      $display("FAIL stream_count: got %0d outs over %0d cycles want 16 over 15", nout, last - first);
    end
  endtask

  task automatic test_async_reset();
    logic stale = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    y_arr = mk(128, 128, 128, 128);
    grad_arr = mk(256, 256, 256, 256);
    tick();
    grad_arr = mk(512, 512, 512, 512);
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL arst_preflight: got %b want 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || grad_out !== '0) begin
      bad++;
      $display("FAIL arst_immediate: got v=%b %h want v=0 0", out_valid, grad_out);
    end
    tick();
    #2 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    total++;
    if (stale) begin bad++; $display("FAIL arst_stale: got out_valid=1 want 0"); end
    test_vector("arst_after", mk(128, 192, 1, 0), mk(256, -512, 256, 1280), mk(64, -96, 1, 0));
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_extremes();
    test_backpressure();
    test_stream();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
